multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM that sequences the shared multicycle MIPS datapath: one memory port, one ALU, IR/A/B/ALUOut regs.
//  Supports add/sub/or/slt (op 0x00), lw 0x23, sw 0x2b, beq 0x04, bne 0x05, j 0x02 and addi 0x08.
//  Sits between the instruction register (opcode/funct) and the datapath muxes/enables.
//  Handshakes with unified memory via mem_req/mem_ready and counts retired instructions.
// PARAMETERS
//  CNT_W   32  width of retired-instruction counter instret
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous reset, active-low
//  opcode       in   6      IR[31:26], valid from DECODE onward
//  funct        in   6      IR[5:0]
//  mem_ready    in   1      memory completes current access this cycle
//  mem_req      out  1      memory access request, held until mem_ready
//  mem_we       out  1      write (valid with mem_req)
//  i_or_d       out  1      address mux: 0=PC, 1=ALUOut
//  ir_write     out  1      load IR
//  pc_write     out  1      unconditional PC load
//  pc_wr_eq     out  1      PC load if ALU zero (beq)
//  pc_wr_ne     out  1      PC load if !zero (bne)
//  pc_source    out  2      00=ALU result, 01=ALUOut, 10=jump target
//  alu_src_a    out  1      0=PC, 1=reg A
//  alu_src_b    out  2      00=B, 01=const 4, 10=sext imm, 11=sext imm<<2
//  alu_control  out  3      010 add, 110 sub, 001 or, 111 slt
//  reg_dst      out  1      1=rd, 0=rt
//  mem_to_reg   out  1      1=MDR, 0=ALUOut
//  reg_write    out  1      register-file write enable
//  state        out  4      current state (debug)
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  States: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC6 RWB7 BRANCH8 JUMP9 IEXEC10 IWB11 TRAP12.
//  Reset (rst_n=0 at edge): state=FETCH, instret=0; all outputs derive from state, so with
//   mem_ready=0 all strobes are 0 except mem_req=1, i_or_d=0.
//  FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_source=00.
//   ir_write=pc_write=mem_ready (combinational gate). Stay while !mem_ready; else -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, add (branch target to ALUOut). Next by opcode:
//   lw/sw->MEMADR, R->EXEC, beq/bne->BRANCH, j->JUMP, addi->IEXEC, other->illegal.
//  MEMADR: alu_src_a=1, alu_src_b=10, add; lw->MEMRD, sw->MEMWR.
//  MEMRD: mem_req=1, i_or_d=1; wait for mem_ready -> MEMWB.
//  MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; ->FETCH.
//  MEMWR: mem_req=1, mem_we=1, i_or_d=1; wait for mem_ready -> FETCH.
//  EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct (0x20 add, 0x22 sub, 0x25 or, 0x2a slt);
//   other funct = illegal. ->RWB. RWB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_source=01; pc_wr_eq (beq) or pc_wr_ne (bne)=1; ->FETCH.
//  JUMP: pc_write=1, pc_source=10; ->FETCH. IEXEC: alu_src_a=1, alu_src_b=10, add; ->IWB.
//  IWB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
//  Latency at zero wait: lw 5 cycles; R/sw/addi 4; beq/bne/j 3. Each mem wait adds 1 cycle.
//  instret += 1 on the final cycle of each instruction (MEMWB, MEMWR&mem_ready, RWB, IWB, BRANCH, JUMP);
//   wraps modulo 2^CNT_W.
//  mem_req never drops while waiting; mem_we, i_or_d stable until mem_ready.
//  Reset mid-access: pending request is abandoned, next cycle is FETCH with PC unchanged by ctrl.
//  Unlisted outputs are 0 in every state.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: illegal opcode/funct -> TRAP: all strobes 0, state=12, no retire;
//   held until reset.
//  Undefined: illegal instruction behaves as NOP: DECODE -> FETCH (EXEC on bad funct -> FETCH,
//   no reg_write); instret still increments.
// TESTING
//  rst_n=0 2 cycles, mem_ready=0 -> state=0, instret=0, mem_req=1, pc_write=ir_write=0.
//  lw (op 0x23), mem_ready=1 always -> states 0,1,2,3,4; reg_write=1 only in 4 with mem_to_reg=1; instret=1.
//  sw with mem_ready low 3 cycles in MEMWR -> mem_req=mem_we=1 held 4 cycles, then FETCH; no reg_write.
//  add/sub/or/slt funct 0x20/0x22/0x25/0x2a -> EXEC alu_control 010/110/001/111, RWB reg_dst=1.
//  beq then bne then j -> 3 cycles each, pc_wr_eq, pc_wr_ne, pc_write+pc_source=10 respectively; instret=+3.
//  op 0x3f -> with ILLEGAL_TRAP_EN state=12 held; without, back to FETCH after DECODE, instret+1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared multicycle MIPS datapath, with retired-instruction counter.
// Define ILLEGAL_TRAP_EN to park illegal instructions in TRAP; otherwise they retire as NOPs.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_wr_eq,
  output logic             pc_wr_ne,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StIExec  = 4'd10,
    StIwb    = 4'd11,
    StTrap   = 4'd12
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       fetch;
    logic       jump;
    logic       pc_wr_eq;
    logic       pc_wr_ne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpAddi  = 6'h08;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  function automatic logic funct_ok(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h25) || (fn == 6'h2a);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    logic [2:0] a;
    case (fn)
      6'h20:   a = AluAdd;
      6'h22:   a = AluSub;
      6'h25:   a = AluOr;
      6'h2a:   a = AluSlt;
      default: a = 3'b000;
    endcase
    return a;
  endfunction

  // Moore decode of one state; opcode/funct are stable from DECODE onward.
  function automatic ctrl_t decode(input state_e st, input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: begin
        c.mem_req     = 1'b1;
        c.fetch       = 1'b1;
        c.alu_src_b   = 2'b01;
        c.alu_control = AluAdd;
      end
      StDecode: begin
        c.alu_src_b   = 2'b11;
        c.alu_control = AluAdd;
      end
      StMemAdr, StIExec: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = 2'b10;
        c.alu_control = AluAdd;
      end
      StMemRd: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.i_or_d  = 1'b1;
      end
      StExec: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = funct_alu(fn);
      end
      StRwb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      StBranch: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = AluSub;
        c.pc_source   = 2'b01;
        c.pc_wr_eq    = (op == OpBeq);
        c.pc_wr_ne    = (op == OpBne);
      end
      StJump: begin
        c.jump      = 1'b1;
        c.pc_source = 2'b10;
      end
      StIwb:   c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw:   state_d = StMemAdr;
          OpRtype:      state_d = StExec;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:          state_d = StJump;
          OpAddi:       state_d = StIExec;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = StTrap;
`else
            state_d = StFetch;
            retire  = 1'b1;
`endif
          end
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: if (mem_ready) begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StExec: begin
        if (funct_ok(funct)) begin
          state_d = StRwb;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          state_d = StFetch;
          retire  = 1'b1;
`endif
        end
      end
      StRwb, StIwb, StBranch, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StIExec: state_d = StIwb;
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet still Moore-timed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      ctrl_q    <= decode(StFetch, 6'h00, 6'h00);
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d, opcode, funct);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // FETCH loads IR and PC+4 only in the cycle memory completes.
  assign ir_write    = ctrl_q.fetch & mem_ready;
  assign pc_write    = ctrl_q.jump | (ctrl_q.fetch & mem_ready);
  assign mem_req     = ctrl_q.mem_req;
  assign mem_we      = ctrl_q.mem_we;
  assign i_or_d      = ctrl_q.i_or_d;
  assign pc_wr_eq    = ctrl_q.pc_wr_eq;
  assign pc_wr_ne    = ctrl_q.pc_wr_ne;
  assign pc_source   = ctrl_q.pc_source;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign alu_control = ctrl_q.alu_control;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_write   = ctrl_q.reg_write;
  assign state       = state_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle trace model built from instruction class,
// memory wait counts and a wrapping retire counter (narrow CNT_W so wrap is exercised).
module tb_multicycle_ctrl;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode, funct;
  logic          mem_ready;
  logic          mem_req, mem_we, i_or_d, ir_write, pc_write, pc_wr_eq, pc_wr_ne;
  logic [1:0]    pc_source, alu_src_b;
  logic          alu_src_a, reg_dst, mem_to_reg, reg_write;
  logic [2:0]    alu_control;
  logic [3:0]    state;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_wr_eq(pc_wr_eq), .pc_wr_ne(pc_wr_ne), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .state(state),
    .instret(instret)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_wr_eq;
    logic       pc_wr_ne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
  } step_t;

  step_t         plan[$];
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] model_cnt = '0;

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08};
  endfunction

  function automatic bit legal_fn(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h25, 6'h2a};
  endfunction

  function automatic outs_t expect_outs(input logic [3:0] st, input logic [5:0] op,
                                        input logic [5:0] fn, input logic rdy);
    outs_t e;
    e = '0;
    case (st)
      4'd0: begin
        e.mem_req = 1; e.alu_src_b = 2'b01; e.alu_control = 3'b010;
        e.ir_write = rdy; e.pc_write = rdy;
      end
      4'd1: begin e.alu_src_b = 2'b11; e.alu_control = 3'b010; end
      4'd2, 4'd10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
      4'd3: begin e.mem_req = 1; e.i_or_d = 1; end
      4'd4: begin e.reg_write = 1; e.mem_to_reg = 1; end
      4'd5: begin e.mem_req = 1; e.mem_we = 1; e.i_or_d = 1; end
      4'd6: begin
        e.alu_src_a = 1;
        e.alu_control = (fn == 6'h20) ? 3'b010 : (fn == 6'h22) ? 3'b110 :
                        (fn == 6'h25) ? 3'b001 : (fn == 6'h2a) ? 3'b111 : 3'b000;
      end
      4'd7: begin e.reg_write = 1; e.reg_dst = 1; end
      4'd8: begin
        e.alu_src_a = 1; e.alu_control = 3'b110; e.pc_source = 2'b01;
        e.pc_wr_eq = (op == 6'h04); e.pc_wr_ne = (op == 6'h05);
      end
      4'd9: begin e.pc_write = 1; e.pc_source = 2'b10; end
      4'd11: e.reg_write = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic bit retires(input logic [3:0] st, input logic [5:0] op,
                                 input logic [5:0] fn, input logic rdy);
    bit r;
    r = (st inside {4'd4, 4'd7, 4'd8, 4'd9, 4'd11}) || (st == 4'd5 && rdy);
`ifndef ILLEGAL_TRAP_EN
    if (st == 4'd1 && !legal_op(op)) r = 1;
    if (st == 4'd6 && !legal_fn(fn)) r = 1;
`endif
    return r;
  endfunction

  // Entered at posedge+1; leaves at the following posedge+1.
  task automatic check_cycle(input step_t s);
    outs_t obs, exp;
    mem_ready = s.rdy;
    @(negedge clk);
    obs = '{mem_req, mem_we, i_or_d, ir_write, pc_write, pc_wr_eq, pc_wr_ne, pc_source,
            alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg, reg_write};
    exp = expect_outs(s.st, opcode, funct, s.rdy);
    // ALU code for an undecodable funct is unspecified
    if (s.st == 4'd6 && !legal_fn(funct)) obs.alu_control = exp.alu_control;
    checks++;
    assert (state === s.st) else begin
      failures++;
      $error("FAIL state obs=%0d exp=%0d op=%h fn=%h", state, s.st, opcode, funct);
    end
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL outputs st=%0d obs=%h exp=%h", s.st, obs, exp);
    end
    checks++;
    assert (instret === model_cnt) else begin
      failures++;
      $error("FAIL instret obs=%0d exp=%0d", instret, model_cnt);
    end
    @(posedge clk);
    if (retires(s.st, opcode, funct, s.rdy)) model_cnt = model_cnt + 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    assert (state === 4'd0 && instret === '0) else begin
      failures++;
      $error("FAIL reset_state obs=%0d/%0d exp=0/0", state, instret);
    end
    checks++;
    assert ({mem_req, i_or_d, ir_write, pc_write, reg_write, mem_we} === 6'b100000) else begin
      failures++;
      $error("FAIL reset_strobes obs=%b exp=100000",
             {mem_req, i_or_d, ir_write, pc_write, reg_write, mem_we});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_cnt = '0;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int dw, input bit abort);
    bit trapped;
    bit aborted;
    logic [3:0] mst;
    trapped = 0;
    aborted = 0;
    opcode = op;
    funct = fn;
    plan.delete();
    repeat (fw) plan.push_back('{4'd0, 1'b0});
    plan.push_back('{4'd0, 1'b1});
    plan.push_back('{4'd1, 1'($urandom)});
    if (op == 6'h23 || op == 6'h2b) begin
      mst = (op == 6'h23) ? 4'd3 : 4'd5;
      plan.push_back('{4'd2, 1'($urandom)});
      repeat (dw) plan.push_back('{mst, 1'b0});
      if (abort) aborted = 1;
      else begin
        plan.push_back('{mst, 1'b1});
        if (op == 6'h23) plan.push_back('{4'd4, 1'($urandom)});
      end
    end else if (op == 6'h00) begin
      plan.push_back('{4'd6, 1'($urandom)});
      if (legal_fn(fn)) plan.push_back('{4'd7, 1'($urandom)});
`ifdef ILLEGAL_TRAP_EN
      else trapped = 1;
`endif
    end else if (op == 6'h04 || op == 6'h05) plan.push_back('{4'd8, 1'($urandom)});
    else if (op == 6'h02) plan.push_back('{4'd9, 1'($urandom)});
    else if (op == 6'h08) begin
      plan.push_back('{4'd10, 1'($urandom)});
      plan.push_back('{4'd11, 1'($urandom)});
    end
`ifdef ILLEGAL_TRAP_EN
    else trapped = 1;
`endif
    if (trapped) repeat (3) plan.push_back('{4'd12, 1'($urandom)});
    foreach (plan[i]) check_cycle(plan[i]);
    if (trapped || aborted) do_reset();
  endtask

  logic [5:0] op_tab[8];
  logic [5:0] fn_tab[6];

  initial begin
    op_tab = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h3f};
    fn_tab = '{6'h20, 6'h22, 6'h25, 6'h2a, 6'h00, 6'h21};
    opcode = 6'h00;
    funct = 6'h20;
    do_reset();
    run_instr(6'h23, 6'h00, 0, 0, 0);
    run_instr(6'h2b, 6'h00, 0, 3, 0);
    run_instr(6'h00, 6'h20, 1, 0, 0);
    run_instr(6'h00, 6'h22, 0, 0, 0);
    run_instr(6'h00, 6'h25, 2, 0, 0);
    run_instr(6'h00, 6'h2a, 0, 0, 0);
    run_instr(6'h04, 6'h00, 0, 0, 0);
    run_instr(6'h05, 6'h00, 0, 0, 0);
    run_instr(6'h02, 6'h00, 0, 0, 0);
    run_instr(6'h08, 6'h00, 0, 0, 0);
    run_instr(6'h3f, 6'h00, 0, 0, 0);
    run_instr(6'h00, 6'h21, 0, 0, 0);
    for (int n = 0; n < 120; n++) begin
      int oi, fi;
      oi = ($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, 6);
      fi = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      run_instr(op_tab[oi], fn_tab[fi], $urandom_range(0, 2), $urandom_range(0, 3), 0);
    end
    run_instr(6'h23, 6'h00, 0, 2, 1);
    run_instr(6'h2b, 6'h00, 1, 1, 1);
    run_instr(6'h23, 6'h00, 0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
